// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Purpose: shared encodings for the riscv_ctrl_seq instruction sequencer.
//   - opcode and funct3 constants for the two supported instructions
//   - the two-state sequencer state type
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } state_t;

endpackage

// File: rtl/riscv_ctrl_seq_imm_gen.sv
// imm_gen
// Purpose: combinational immediate extraction with sign extension.
// Ports:
//   i_irUpper  IR[31:20], the I-type immediate field
//   i_irLower  IR[11:7], carries B-type imm[4:1] and imm[11]
//   o_immI     sign-extended I-immediate
//   o_immB     sign-extended B-immediate (bit 0 always zero)
module imm_gen
   import riscv_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [11:0]           i_irUpper,
   input  logic [4:0]            i_irLower,
   output logic [DATA_WIDTH-1:0] o_immI,
   output logic [DATA_WIDTH-1:0] o_immB
);

   // I-immediate is the top twelve instruction bits, sign-extended.
   assign o_immI = {{(DATA_WIDTH-12){i_irUpper[11]}}, i_irUpper};

   // B-immediate is scattered: {IR[31], IR[7], IR[30:25], IR[11:8], 0}.
   assign o_immB = {{(DATA_WIDTH-13){i_irUpper[11]}},
                    i_irUpper[11], i_irLower[0], i_irUpper[10:5],
                    i_irLower[4:1], 1'b0};

endmodule

// File: rtl/riscv_ctrl_seq.sv
// riscv_ctrl_seq
// Purpose: two-state instruction sequencer/controller for a register-file/ALU
// datapath. Fetches over a req/valid handshake, decodes addi and bne, drives
// register addresses, write enable and operand select, and resolves bne from
// the datapath EQ flag.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_req/instr_addr  fetch request and address (current PC)
//   instr_valid/instr     fetch response
//   EQ                    datapath equality flag, sampled in EXEC
//   AD1/AD2/AD3           rs1/rs2/rd register addresses
//   WE3, ALUsrc, Immop    write enable, operand select, I-immediate
//   illegal               one-cycle pulse on unsupported/misaligned branch
//   retire_cnt            instructions completed
module riscv_ctrl_seq
   import riscv_ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADD_WIDTH  = 5,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  instr_req,
   output logic [DATA_WIDTH-1:0] instr_addr,
   input  logic                  instr_valid,
   input  logic [DATA_WIDTH-1:0] instr,
   input  logic                  EQ,
   output logic [ADD_WIDTH-1:0]  AD1,
   output logic [ADD_WIDTH-1:0]  AD2,
   output logic [ADD_WIDTH-1:0]  AD3,
   output logic                  WE3,
   output logic                  ALUsrc,
   output logic [DATA_WIDTH-1:0] Immop,
   output logic                  illegal,
   output logic [DATA_WIDTH-1:0] retire_cnt
);

   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

   state_t                r_state;
   state_t                w_stateNext;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] w_pcNext;
   logic [DATA_WIDTH-1:0] r_ir;
   logic [DATA_WIDTH-1:0] r_retireCnt;

   logic                  w_isAddi;
   logic                  w_isBne;
   logic [DATA_WIDTH-1:0] w_immI;
   logic [DATA_WIDTH-1:0] w_immB;
   logic [DATA_WIDTH-1:0] w_pcPlus4;
   logic [DATA_WIDTH-1:0] w_brTarget;

   // Field decode runs from IR in every state; only WE3 and illegal are
   // gated by EXEC, so the datapath sees stable addresses throughout.
   assign w_isAddi = (r_ir[6:0] == OP_IMM)    && (r_ir[14:12] == F3_ADDI);
   assign w_isBne  = (r_ir[6:0] == OP_BRANCH) && (r_ir[14:12] == F3_BNE);

   assign AD1    = r_ir[19:15];
   assign AD2    = r_ir[24:20];
   assign AD3    = r_ir[11:7];
   assign ALUsrc = w_isAddi;
   assign Immop  = w_immI;

   imm_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_immGen (
      .i_irUpper (r_ir[31:20]),
      .i_irLower (r_ir[11:7]),
      .o_immI    (w_immI),
      .o_immB    (w_immB)
   );

   // PC arithmetic wraps naturally at the register width.
   assign w_pcPlus4  = r_pc + PC_STEP;
   assign w_brTarget = r_pc + w_immB;

   assign instr_addr = r_pc;
   assign retire_cnt = r_retireCnt;

   // State register. Reset forces FETCH asynchronously, which also drops
   // WE3 at once so a reset during EXEC cannot leave a partial write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state, next-PC and control outputs. A taken bne whose target is
   // only 2-aligned is treated as illegal and falls through to PC+4.
   always_comb begin
      w_stateNext = r_state;
      w_pcNext    = r_pc;
      instr_req   = 1'b0;
      WE3         = 1'b0;
      illegal     = 1'b0;
      case (r_state)
         FETCH: begin
            instr_req = 1'b1;
            if (instr_valid) begin
               w_stateNext = EXEC;
            end
         end
         EXEC: begin
            w_stateNext = FETCH;
            w_pcNext    = w_pcPlus4;
            WE3         = w_isAddi;
            if (w_isBne && !EQ) begin
               if (w_brTarget[1]) begin
                  illegal = 1'b1;
               end else begin
                  w_pcNext = w_brTarget;
               end
            end
            if (!w_isAddi && !w_isBne) begin
               illegal = 1'b1;
            end
         end
         default: begin
            w_stateNext = FETCH;
         end
      endcase
   end

   // PC, instruction register and retire counter. IR loads only on an
   // accepted fetch; every EXEC cycle retires, illegal ones included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= RESET_PC;
         r_ir        <= '0;
         r_retireCnt <= '0;
      end else begin
         r_pc <= w_pcNext;
         if (r_state == FETCH && instr_valid) begin
            r_ir <= instr;
         end
         if (r_state == EXEC) begin
            r_retireCnt <= r_retireCnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_riscv_ctrl_seq.sv
// tb_riscv_ctrl_seq
// Purpose: self-checking bench for riscv_ctrl_seq. Each fetched instruction
// pushes its expected EXEC-cycle behaviour onto a scoreboard; the EXEC cycle
// pops and compares it, then the following fetch checks PC and retire count.
module tb_riscv_ctrl_seq;

   logic        clk;
   logic        rst_n;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_valid;
   logic [31:0] instr;
   logic        EQ;
   logic [4:0]  AD1;
   logic [4:0]  AD2;
   logic [4:0]  AD3;
   logic        WE3;
   logic        ALUsrc;
   logic [31:0] Immop;
   logic        illegal;
   logic [31:0] retire_cnt;

   typedef struct {
      logic [4:0]  ad1;
      logic [4:0]  ad2;
      logic [4:0]  ad3;
      logic        we3;
      logic        aluSrc;
      logic        illegal;
      logic [31:0] immop;
      logic [31:0] nextPc;
   } expect_t;

   expect_t     scoreboard[$];
   logic [31:0] mPc;
   logic [31:0] mRetire;
   int          checkCount;
   int          failCount;

   riscv_ctrl_seq #(
      .DATA_WIDTH (32),
      .ADD_WIDTH  (5),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_req   (instr_req),
      .instr_addr  (instr_addr),
      .instr_valid (instr_valid),
      .instr       (instr),
      .EQ          (EQ),
      .AD1         (AD1),
      .AD2         (AD2),
      .AD3         (AD3),
      .WE3         (WE3),
      .ALUsrc      (ALUsrc),
      .Immop       (Immop),
      .illegal     (illegal),
      .retire_cnt  (retire_cnt)
   );

   // Free-running 10 ns clock; stimulus and sampling happen on negedges.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a handshake never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Waits for the fetch request, optionally stalls, then presents the word
   // and pushes the reference behaviour onto the scoreboard. Returns at the
   // negedge inside the EXEC cycle.
   task automatic applyStimulus(input logic [31:0] word, input logic eq, input int stallCycles);
      expect_t     e;
      logic [31:0] immB;
      logic [31:0] tgt;
      logic        isAddi;
      logic        isBne;
      int          waitCycles;
      waitCycles = 0;
      while (instr_req !== 1'b1 && waitCycles < 10) begin
         @(negedge clk);
         waitCycles++;
      end
      checkCount++;
      if (instr_req !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL fetchReq: got %b want 1 (timeout)", instr_req);
      end
      checkCount++;
      if (instr_addr !== mPc) begin
         failCount++;
         $display("[TB] FAIL fetchAddr: got %h want %h", instr_addr, mPc);
      end
      instr       = word;
      EQ          = eq;
      instr_valid = 1'b0;
      for (int i = 0; i < stallCycles; i++) begin
         @(negedge clk);
         checkCount++;
         if (instr_req !== 1'b1 || instr_addr !== mPc || WE3 !== 1'b0 || retire_cnt !== mRetire) begin
            failCount++;
            $display("[TB] FAIL stallHold: req=%b addr=%h we3=%b retire=%0d want req=1 addr=%h we3=0 retire=%0d",
                     instr_req, instr_addr, WE3, retire_cnt, mPc, mRetire);
         end
      end
      isAddi   = (word[6:0] == 7'b0010011) && (word[14:12] == 3'b000);
      isBne    = (word[6:0] == 7'b1100011) && (word[14:12] == 3'b001);
      e.ad1    = word[19:15];
      e.ad2    = word[24:20];
      e.ad3    = word[11:7];
      e.immop  = {{20{word[31]}}, word[31:20]};
      e.we3    = isAddi;
      e.aluSrc = isAddi;
      e.illegal = !(isAddi || isBne);
      e.nextPc = mPc + 32'd4;
      immB     = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
      tgt      = mPc + immB;
      if (isBne && !eq) begin
         if (tgt[1]) e.illegal = 1'b1;
         else        e.nextPc  = tgt;
      end
      scoreboard.push_back(e);
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   // Pops the oldest expectation and compares the EXEC cycle, then steps to
   // the next fetch and checks PC, retire count and deasserted pulses.
   task automatic checkOutput();
      expect_t e;
      checkCount++;
      if (scoreboard.size() == 0) begin
         failCount++;
         $display("[TB] FAIL scoreboardEmpty: got 0 entries want 1");
         return;
      end
      e = scoreboard.pop_front();
      checkCount++;
      if (instr_req !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL execReq: got %b want 0", instr_req);
      end
      checkCount++;
      if (AD1 !== e.ad1 || AD2 !== e.ad2 || AD3 !== e.ad3) begin
         failCount++;
         $display("[TB] FAIL regAddr: got %0d/%0d/%0d want %0d/%0d/%0d", AD1, AD2, AD3, e.ad1, e.ad2, e.ad3);
      end
      checkCount++;
      if (WE3 !== e.we3) begin
         failCount++;
         $display("[TB] FAIL we3: got %b want %b", WE3, e.we3);
      end
      checkCount++;
      if (ALUsrc !== e.aluSrc) begin
         failCount++;
         $display("[TB] FAIL aluSrc: got %b want %b", ALUsrc, e.aluSrc);
      end
      checkCount++;
      if (Immop !== e.immop) begin
         failCount++;
         $display("[TB] FAIL immop: got %h want %h", Immop, e.immop);
      end
      checkCount++;
      if (illegal !== e.illegal) begin
         failCount++;
         $display("[TB] FAIL illegal: got %b want %b", illegal, e.illegal);
      end
      checkCount++;
      if (retire_cnt !== mRetire) begin
         failCount++;
         $display("[TB] FAIL execRetire: got %0d want %0d", retire_cnt, mRetire);
      end
      mRetire = mRetire + 32'd1;
      mPc     = e.nextPc;
      @(negedge clk);
      checkCount++;
      if (instr_req !== 1'b1 || instr_addr !== mPc) begin
         failCount++;
         $display("[TB] FAIL nextFetch: req=%b addr=%h want req=1 addr=%h", instr_req, instr_addr, mPc);
      end
      checkCount++;
      if (retire_cnt !== mRetire) begin
         failCount++;
         $display("[TB] FAIL retireCnt: got %0d want %0d", retire_cnt, mRetire);
      end
      checkCount++;
      if (illegal !== 1'b0 || WE3 !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL pulseClear: illegal=%b we3=%b want 0/0", illegal, WE3);
      end
   endtask

   // Holds reset for three cycles and checks the idle outputs and the first
   // fetch request after release.
   task automatic test_reset();
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = 32'h0;
      EQ          = 1'b0;
      repeat (3) @(negedge clk);
      checkCount++;
      if (instr_addr !== 32'h0 || WE3 !== 1'b0 || retire_cnt !== 32'h0 || illegal !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL resetState: addr=%h we3=%b retire=%0d illegal=%b want 0/0/0/0",
                  instr_addr, WE3, retire_cnt, illegal);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checkCount++;
      if (instr_req !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL resetReq: got %b want 1", instr_req);
      end
      mPc     = 32'h0;
      mRetire = 32'h0;
      scoreboard.delete();
   endtask

   task automatic test_addi();
      applyStimulus(32'h0050_0513, 1'b0, 0);
      checkOutput();
      checkCount++;
      if (instr_addr !== 32'd4 || retire_cnt !== 32'd1) begin
         failCount++;
         $display("[TB] FAIL addiResult: addr=%h retire=%0d want 4/1", instr_addr, retire_cnt);
      end
   endtask

   // bne x10,x11,-4 from PC=8: taken lands on 4, not taken on 12.
   task automatic test_bne();
      applyStimulus(32'h0050_0513, 1'b0, 0);
      checkOutput();
      applyStimulus(32'hFEB5_1EE3, 1'b0, 0);
      checkOutput();
      checkCount++;
      if (instr_addr !== 32'd4) begin
         failCount++;
         $display("[TB] FAIL bneTaken: got %h want 00000004", instr_addr);
      end
      applyStimulus(32'h0050_0513, 1'b0, 0);
      checkOutput();
      applyStimulus(32'hFEB5_1EE3, 1'b1, 0);
      checkOutput();
      checkCount++;
      if (instr_addr !== 32'd12) begin
         failCount++;
         $display("[TB] FAIL bneNotTaken: got %h want 0000000c", instr_addr);
      end
   endtask

   task automatic test_fetch_stall();
      applyStimulus(32'h0050_0513, 1'b0, 5);
      checkOutput();
   endtask

   // Unsupported encoding, then a negative addi immediate.
   task automatic test_illegal();
      applyStimulus(32'h0000_0033, 1'b0, 0);
      checkOutput();
      applyStimulus(32'hFFF0_8093, 1'b0, 0);
      checkCount++;
      if (Immop !== 32'hFFFF_FFFF) begin
         failCount++;
         $display("[TB] FAIL negImm: got %h want ffffffff", Immop);
      end
      checkOutput();
   endtask

   // bne x1,x2,+2: a taken target with bit1 set is illegal and falls through.
   task automatic test_misaligned_branch();
      logic [31:0] startPc;
      startPc = mPc;
      applyStimulus(32'h0020_9163, 1'b0, 0);
      checkCount++;
      if (illegal !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL misalignIllegal: got %b want 1", illegal);
      end
      checkOutput();
      checkCount++;
      if (instr_addr !== startPc + 32'd4) begin
         failCount++;
         $display("[TB] FAIL misalignPc: got %h want %h", instr_addr, startPc + 32'd4);
      end
      applyStimulus(32'h0020_9163, 1'b1, 0);
      checkOutput();
   endtask

   // Reset dropped inside an addi EXEC cycle must kill WE3 without a clock.
   task automatic test_reset_mid_exec();
      applyStimulus(32'h0050_0513, 1'b0, 0);
      checkCount++;
      if (WE3 !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL midExecWe3: got %b want 1", WE3);
      end
      #1 rst_n = 1'b0;
      #1;
      checkCount++;
      if (WE3 !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL asyncWe3Drop: got %b want 0", WE3);
      end
      scoreboard.delete();
      @(negedge clk);
      rst_n   = 1'b1;
      mPc     = 32'h0;
      mRetire = 32'h0;
      @(negedge clk);
      checkCount++;
      if (instr_addr !== 32'h0 || retire_cnt !== 32'h0 || instr_req !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL postResetState: addr=%h retire=%0d req=%b want 0/0/1", instr_addr, retire_cnt, instr_req);
      end
   endtask

   // From PC=0 a bne of -4 wraps to 0xFFFFFFFC; the next +4 wraps to 0.
   task automatic test_wrap();
      applyStimulus(32'hFEB5_1EE3, 1'b0, 0);
      checkOutput();
      checkCount++;
      if (instr_addr !== 32'hFFFF_FFFC) begin
         failCount++;
         $display("[TB] FAIL wrapLow: got %h want fffffffc", instr_addr);
      end
      applyStimulus(32'h0050_0513, 1'b0, 0);
      checkOutput();
      checkCount++;
      if (instr_addr !== 32'h0) begin
         failCount++;
         $display("[TB] FAIL wrapHigh: got %h want 00000000", instr_addr);
      end
   endtask

   // Back-to-back random addi instructions with no fetch wait states.
   task automatic test_back_to_back();
      logic [31:0] word;
      for (int i = 0; i < 8; i++) begin
         word = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0010011};
         applyStimulus(word, 1'($urandom), 0);
         checkOutput();
      end
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      mPc        = 32'h0;
      mRetire    = 32'h0;
      rst_n      = 1'b0;
      instr_valid = 1'b0;
      instr      = 32'h0;
      EQ         = 1'b0;
      test_reset();
      test_addi();
      test_bne();
      test_fetch_stall();
      test_illegal();
      test_misaligned_branch();
      test_back_to_back();
      test_reset_mid_exec();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
